// File: rtl/priority_arbiter_4.sv
// -----------------------------------------------------------------------------
// priority_arbiter_4
//
// Four-requester arbiter that holds a single grant until the owner signals
// done, drops its request, or has held the resource for MAX_HOLD cycles.
// A forced release (hold limit only) produces a one-cycle timeout pulse.
// Between any two grants there is always at least one cycle with no grant.
//
// Optional feature:
//   PRIORITY_ARBITER_ROUND_ROBIN_EN
//     undefined : fixed priority, requester 3 highest, requester 0 lowest.
//     defined   : rotating priority. The last granted index L is remembered
//                 and the search order is L-1, L-2, L-3, L (mod 4).
//   After reset both builds pick the same first winner, because the
//   rotation base starts at 0 and 0-1 = 3 gives order 3,2,1,0.
//
// Parameters:
//   MAX_HOLD  maximum BUSY cycles per grant before a forced release (1..255)
//
// Ports:
//   clk      in   1  clock, all state changes on the rising edge
//   rst      in   1  synchronous active-high reset
//   req      in   4  request per requester, bit k is requester k
//   done     in   1  owner releases the resource (ignored while idle)
//   gnt      out  4  registered one-hot grant
//   gnt_id   out  2  registered binary index of the granted requester
//   v        out  1  registered grant valid (|gnt)
//   timeout  out  1  registered one-cycle pulse after a forced release
// -----------------------------------------------------------------------------
module priority_arbiter_4 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       v,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter value at which the current grant is forcibly released.
    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [3:0]  gnt_reg, gnt_next;
    logic [1:0]  id_reg, id_next;
    logic        v_reg, v_next;
    logic        timeout_reg, timeout_next;

    // Base of the priority rotation: candidate k (k = 0 is searched first)
    // is requester (base - 1 - k) mod 4.
    logic [1:0]  base_idx;

`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
    logic [1:0]  last_reg, last_next;
    assign base_idx = last_reg;
`else
    assign base_idx = 2'd0;
`endif

    // -------------------------------------------------------------------------
    // Winner selection: build the candidate list in search order, then take
    // the first candidate that is requesting.
    // -------------------------------------------------------------------------
    logic [1:0]  cand_idx [4];
    logic [3:0]  cand_req;
    logic        win_any;
    logic [1:0]  win_id;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_cand
            // 2-bit subtraction wraps naturally, giving the mod-4 rotation.
            assign cand_idx[gi] = base_idx - 2'(gi + 1);
            assign cand_req[gi] = req[cand_idx[gi]];
        end
    endgenerate

    assign win_any = |cand_req;

    always_comb begin
        win_id = cand_idx[3];
        // Walk from the lowest-priority candidate upward so the
        // highest-priority requesting candidate is the last to assign.
        for (int k = 3; k >= 0; k--) begin
            if (cand_req[k]) begin
                win_id = cand_idx[k];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Release conditions while BUSY. Owner-driven release (done or request
    // drop) wins over the hold limit, so timeout only fires when the counter
    // alone caused the release.
    // -------------------------------------------------------------------------
    logic owner_release;
    logic at_limit;
    logic leave_busy;

    assign owner_release = done | ~req[id_reg];
    assign at_limit      = (cnt_reg == HOLD_LIMIT);
    assign leave_busy    = owner_release | at_limit;

    // -------------------------------------------------------------------------
    // State register (and all other registers).
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= 8'd0;
            gnt_reg     <= 4'd0;
            id_reg      <= 2'd0;
            v_reg       <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            gnt_reg     <= gnt_next;
            id_reg      <= id_next;
            v_reg       <= v_next;
            timeout_reg <= timeout_next;
        end
    end

`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= 2'd0;
        end else begin
            last_reg <= last_next;
        end
    end

    // The pointer only moves when a new grant is issued.
    always_comb begin
        last_next = last_reg;
        if (state_reg == IDLE && win_any) begin
            last_next = win_id;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state logic, including the hold counter.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = 8'd0;
                if (win_any) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (leave_busy) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end else if (cnt_reg != 8'hFF) begin
                    // Saturating increment; with a legal MAX_HOLD the limit
                    // is always reached before the counter could wrap.
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: next values of the registered outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_next     = gnt_reg;
        id_next      = id_reg;
        v_next       = v_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (win_any) begin
                    gnt_next = 4'b0001 << win_id;
                    id_next  = win_id;
                    v_next   = 1'b1;
                end else begin
                    gnt_next = 4'd0;
                    id_next  = 2'd0;
                    v_next   = 1'b0;
                end
            end
            BUSY: begin
                if (leave_busy) begin
                    gnt_next     = 4'd0;
                    id_next      = 2'd0;
                    v_next       = 1'b0;
                    timeout_next = at_limit & ~owner_release;
                end
            end
            default: begin
                gnt_next = 4'd0;
                id_next  = 2'd0;
                v_next   = 1'b0;
            end
        endcase
    end

    assign gnt     = gnt_reg;
    assign gnt_id  = id_reg;
    assign v       = v_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_priority_arbiter_4.sv
// -----------------------------------------------------------------------------
// tb_priority_arbiter_4
//
// Two arbiter instances share the same stimulus: dut_a with MAX_HOLD=3 and
// dut_b with MAX_HOLD=2. A directed vector table exercises dut_a, hand
// sequences exercise dut_b's hold-limit corners, and a random phase checks
// both instances against a behavioural model each cycle.
// -----------------------------------------------------------------------------
module tb_priority_arbiter_4;

`ifdef PRIORITY_ARBITER_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'd0;
    logic       done = 1'b0;

    logic [3:0] gnt_a, gnt_b;
    logic [1:0] id_a, id_b;
    logic       v_a, v_b;
    logic       to_a, to_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    priority_arbiter_4 #(.MAX_HOLD(3)) dut_a (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_a), .gnt_id(id_a), .v(v_a), .timeout(to_a)
    );

    priority_arbiter_4 #(.MAX_HOLD(2)) dut_b (
        .clk(clk), .rst(rst), .req(req), .done(done),
        .gnt(gnt_b), .gnt_id(id_b), .v(v_b), .timeout(to_b)
    );

    // ---------------------------------------------------------------- model
    typedef struct {
        bit busy;
        int owner;
        int cnt;
        int last;
        bit to;
    } mstate_t;

    function automatic mstate_t mreset();
        mstate_t s;
        s.busy = 0; s.owner = 0; s.cnt = 0; s.last = 0; s.to = 0;
        return s;
    endfunction

    function automatic mstate_t mstep(mstate_t s, bit r, bit [3:0] q, bit d, int mh);
        mstate_t n;
        int idx;
        n = s;
        n.to = 0;
        if (r) return mreset();
        if (!s.busy) begin
            // Search order: base-1, base-2, base-3, base (mod 4)
            for (int k = 1; k <= 4; k++) begin
                idx = (((RR ? s.last : 0) - k) % 4 + 4) % 4;
                if (q[idx]) begin
                    n.busy = 1; n.owner = idx; n.cnt = 0;
                    if (RR) n.last = idx;
                    break;
                end
            end
        end else begin
            if (d || !q[s.owner]) begin
                n.busy = 0; n.owner = 0; n.cnt = 0;
            end else if (s.cnt == mh - 1) begin
                n.busy = 0; n.owner = 0; n.cnt = 0; n.to = 1;
            end else begin
                n.cnt = s.cnt + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [7:0] mpack(mstate_t s);
        logic [3:0] g;
        logic [1:0] id;
        g  = s.busy ? (4'b0001 << s.owner) : 4'b0000;
        id = s.busy ? 2'(s.owner) : 2'd0;
        return {g, id, s.busy, s.to};
    endfunction

    // ---------------------------------------------------------------- helpers
    task automatic step(input logic r_i, input logic [3:0] q_i, input logic d_i);
        rst  = r_i;
        req  = q_i;
        done = d_i;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Outputs packed as {gnt[3:0], gnt_id[1:0], v, timeout}
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual gnt=%b id=%0d v=%b to=%b required gnt=%b id=%0d v=%b to=%b",
                     name, act[7:4], act[3:2], act[1], act[0],
                     exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // ---------------------------------------------------------------- table
    typedef struct {
        logic       r;
        logic [3:0] q;
        logic       d;
        logic [3:0] eg;
        logic [1:0] eid;
        logic       ev;
        logic       eto;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] q, input logic d,
                       input logic [3:0] eg, input logic [1:0] eid,
                       input logic ev, input logic eto);
        vec_t t;
        t.r = r; t.q = q; t.d = d; t.eg = eg; t.eid = eid; t.ev = ev; t.eto = eto;
        vecs.push_back(t);
    endtask

    mstate_t ma, mb;
    logic [3:0] rq;
    logic       rr_rst, rd;

    initial begin
        // Basic grant, done release (MAX_HOLD=3 on dut_a)
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0110, 0, 4'b0100, 2, 1, 0);
        add(0, 4'b0110, 0, 4'b0100, 2, 1, 0);
        add(0, 4'b0110, 0, 4'b0100, 2, 1, 0);
        add(0, 4'b0110, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // Forced release after 3 cycles, timeout pulse, regrant
        add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
        add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
        add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
        add(0, 4'b0001, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b0001, 0, 4'b0001, 0, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // All requesting, done pulsed at end of each grant
        add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        if (RR) add(0, 4'b1111, 0, 4'b0100, 2, 1, 0);
        else    add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        if (RR) add(0, 4'b1111, 0, 4'b0010, 1, 1, 0);
        else    add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        if (RR) add(0, 4'b1111, 0, 4'b0001, 0, 1, 0);
        else    add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        // Owner 1, other bits toggled, then req[1] dropped
        add(0, 4'b0010, 0, 4'b0010, 1, 1, 0);
        add(0, 4'b1011, 0, 4'b0010, 1, 1, 0);
        add(0, 4'b0101, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // Reset mid-BUSY with done, pointer back to 0
        add(0, 4'b0100, 0, 4'b0100, 2, 1, 0);
        add(1, 4'b1111, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 0, 4'b1000, 3, 1, 0);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 1, 4'b0000, 0, 0, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].q, vecs[i].d);
            $display("vec %0d rst=%b req=%b done=%b -> gnt=%b id=%0d v=%b to=%b",
                     i, vecs[i].r, vecs[i].q, vecs[i].d, gnt_a, id_a, v_a, to_a);
            chk($sformatf("vec%0d", i), {gnt_a, id_a, v_a, to_a},
                {vecs[i].eg, vecs[i].eid, vecs[i].ev, vecs[i].eto});
        end

        // MAX_HOLD=2: done at the limit edge wins, timeout stays low
        step(1, 4'b0000, 0); chk("b_reset",     {gnt_b, id_b, v_b, to_b}, 8'b0000_00_0_0);
        step(0, 4'b0001, 0); chk("b_grant",     {gnt_b, id_b, v_b, to_b}, 8'b0001_00_1_0);
        step(0, 4'b0001, 0); chk("b_hold",      {gnt_b, id_b, v_b, to_b}, 8'b0001_00_1_0);
        step(0, 4'b0001, 1); chk("b_done_lim",  {gnt_b, id_b, v_b, to_b}, 8'b0000_00_0_0);
        step(0, 4'b0000, 1); chk("b_idle_done", {gnt_b, id_b, v_b, to_b}, 8'b0000_00_0_0);
        step(0, 4'b0000, 1); chk("b_idle_done2",{gnt_b, id_b, v_b, to_b}, 8'b0000_00_0_0);
        // MAX_HOLD=2: pure forced release
        step(0, 4'b0001, 0); chk("b_grant2",    {gnt_b, id_b, v_b, to_b}, 8'b0001_00_1_0);
        step(0, 4'b0001, 0); chk("b_hold2",     {gnt_b, id_b, v_b, to_b}, 8'b0001_00_1_0);
        step(0, 4'b0001, 0); chk("b_timeout",   {gnt_b, id_b, v_b, to_b}, 8'b0000_00_0_1);
        step(0, 4'b0000, 0); chk("b_to_clear",  {gnt_b, id_b, v_b, to_b}, 8'b0000_00_0_0);
        $display("hand sequences on MAX_HOLD=2 instance complete");

        // Random phase against the model
        step(1, 4'b0000, 0);
        ma = mreset();
        mb = mreset();
        rq = 4'd0;
        for (int n = 0; n < 1500; n++) begin
            rr_rst = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
            rd = ($urandom_range(0, 7) == 0);
            step(rr_rst, rq, rd);
            ma = mstep(ma, rr_rst, rq, rd, 3);
            mb = mstep(mb, rr_rst, rq, rd, 2);
            $display("rnd %0d rst=%b req=%b done=%b -> a:gnt=%b to=%b b:gnt=%b to=%b",
                     n, rr_rst, rq, rd, gnt_a, to_a, gnt_b, to_b);
            chk($sformatf("rnd_a%0d", n), {gnt_a, id_a, v_a, to_a}, mpack(ma));
            chk($sformatf("rnd_b%0d", n), {gnt_b, id_b, v_b, to_b}, mpack(mb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
